riva_seq_div: RTL and testbench

Sequential, parametrised integer divider computing floor(A/B) and A mod B for unsigned operands, the multi-cycle hardware successor to the package's combinational `div_power2_by_int` helper. It generalises the helper in three ways: it accepts an arbitrary dividend rather than only a power of two, it has configurable widths and radix, and it returns the remainder and a divide-by-zero flag. It sits beside the DIVu/SLDu datapaths to produce stride, tile-count and reshape factors at run time. It uses valid/ready handshakes on both sides and carries an instruction ID tag through unchanged.

---
 rtl/riva_seq_div_pkg.sv | 42 ++++
 rtl/riva_lead_one.sv | 21 ++
 rtl/riva_seq_div.sv | 162 ++++++++++++++++
 tb/tb_riva_seq_div.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riva_seq_div_pkg.sv
// Shared types and elaboration-time helpers for the riva divider datapaths.
// Holds the instruction tag type, divider FSM encoding and request record.
package riva_seq_div_pkg;

  localparam int VID_W   = 4;
  localparam int DIV_AW  = 20;
  localparam int DIV_BW  = 16;
  localparam int DIV_BPC = 1;

  typedef logic [VID_W-1:0] vid_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  typedef struct packed {
    logic [DIV_AW-1:0] a;
    logic [DIV_BW-1:0] b;
    vid_t              id;
  } div_req_t;

  // Ceiling log2 with a floor of 1, so a one-entry range still gets a bit.
  function automatic int custom_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Combinational 2^p / d, intended only for constant expressions.
  function automatic int div_power2_by_int(input int p, input int d);
    return (d == 0) ? 0 : (1 << p) / d;
  endfunction

endpackage

// File: rtl/riva_lead_one.sv
// Index of the most significant set bit of vec; 0 when vec is all zeros.
module riva_lead_one
  import riva_seq_div_pkg::*;
#(
  parameter int W  = 16,
  parameter int OW = custom_clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [OW-1:0] idx
);

  // NOTE: every combinational output gets a default before any conditional
  // write; a path that leaves it unassigned would infer a latch.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = OW'(i);
    end
  end

endmodule

// File: rtl/riva_seq_div.sv
// Multi-cycle unsigned divider: quotient, remainder and divide-by-zero flag,
// with a one-cycle fast path for zero and power-of-two divisors.
module riva_seq_div
  import riva_seq_div_pkg::*;
#(
  parameter int AW  = DIV_AW,
  parameter int BW  = DIV_BW,
  parameter int BPC = DIV_BPC
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  input  vid_t          id_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] q_o,
  output logic [BW-1:0] r_o,
  output logic          div_zero_o,
  output vid_t          id_o
);

  localparam int STEPS = AW / BPC;
  localparam int CW    = custom_clog2(STEPS + 1);
  localparam int LW    = custom_clog2(BW);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!(BPC == 1 || BPC == 2 || BPC == 4) || (AW % BPC) != 0) begin : g_bad_bpc
    $fatal(1, "riva_seq_div: BPC must be 1, 2 or 4 and divide AW");
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    vid_t          id;
  } req_t;

  div_state_e    state_q, state_d;
  logic [BW:0]   p_q, p_d, p_step;
  logic [AW-1:0] q_q, q_d, q_step;
  logic [BW-1:0] b_q, b_d;
  logic [BW-1:0] r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  vid_t          id_q, id_d;

  req_t          req;
  logic [LW-1:0] lead_idx;
  logic          b_pow2;
  logic          accept;

  assign req    = '{a: a_i, b: b_i, id: id_i};
  assign b_pow2 = ((req.b & (req.b - BW'(1))) == '0);

  riva_lead_one #(.W(BW), .OW(LW)) u_lead_one (
    .vec (req.b),
    .idx (lead_idx)
  );

  assign in_ready_o  = !rst_i && !flush_i &&
                       (state_q == DIV_IDLE || (state_q == DIV_DONE && out_ready_i));
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == DIV_DONE);
  assign q_o         = q_q;
  assign r_o         = r_q;
  assign div_zero_o  = dz_q;
  assign id_o        = id_q;

  // NOTE: blocking assignments here chain the BPC restoring sub-steps within
  // one cycle; each iteration reads the value the previous one produced.
  always_comb begin
    p_step = p_q;
    q_step = q_q;
    for (int s = 0; s < BPC; s++) begin
      p_step = {p_step[BW-1:0], q_step[AW-1]};
      q_step = q_step << 1;
      if (p_step >= {1'b0, b_q}) begin
        p_step    = p_step - {1'b0, b_q};
        q_step[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    id_d    = id_q;

    unique case (state_q)
      DIV_IDLE: ;
      DIV_CALC: begin
        p_d   = p_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DIV_DONE;
          r_d     = p_step[BW-1:0];
        end
      end
      DIV_DONE: if (out_ready_i) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase

    // A new request is classified identically whether it arrives in IDLE or
    // on the cycle a finished result leaves DONE.
    if (accept) begin
      b_d   = req.b;
      id_d  = req.id;
      dz_d  = 1'b0;
      cnt_d = '0;
      if (req.b == '0) begin
        q_d     = '0;
        r_d     = BW'(req.a);
        dz_d    = 1'b1;
        state_d = DIV_DONE;
      end else if (b_pow2) begin
        q_d     = req.a >> lead_idx;
        r_d     = BW'(req.a) & (req.b - BW'(1));
        state_d = DIV_DONE;
      end else begin
        p_d     = '0;
        q_d     = req.a;
        state_d = DIV_CALC;
      end
    end

    if (flush_i) state_d = DIV_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DIV_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      id_q    <= id_d;
    end
  end

endmodule

// File: tb/tb_riva_seq_div.sv
// Bench for riva_seq_div: vector table plus handshake corner sequences,
// results checked through an expected-value queue; BPC=1 and BPC=4 instances.
module tb_riva_seq_div;
  import riva_seq_div_pkg::*;

  localparam int AW = 20;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  vid_t          id = '0;

  logic          ir1, ov1, dz1, ir4, ov4, dz4;
  logic [AW-1:0] q1, q4;
  logic [BW-1:0] r1, r4;
  vid_t          id1, id4;

  logic          cur_ir, cur_ov, cur_dz;
  logic [AW-1:0] cur_q;
  logic [BW-1:0] cur_r;
  vid_t          cur_id;

  always #5 clk = ~clk;

  riva_seq_div #(.AW(AW), .BW(BW), .BPC(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid && !sel), .in_ready_o(ir1),
    .a_i(a), .b_i(b), .id_i(id),
    .out_valid_o(ov1), .out_ready_i(out_ready),
    .q_o(q1), .r_o(r1), .div_zero_o(dz1), .id_o(id1)
  );

  riva_seq_div #(.AW(AW), .BW(BW), .BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid && sel), .in_ready_o(ir4),
    .a_i(a), .b_i(b), .id_i(id),
    .out_valid_o(ov4), .out_ready_i(out_ready),
    .q_o(q4), .r_o(r4), .div_zero_o(dz4), .id_o(id4)
  );

  assign cur_ir = sel ? ir4 : ir1;
  assign cur_ov = sel ? ov4 : ov1;
  assign cur_q  = sel ? q4  : q1;
  assign cur_r  = sel ? r4  : r1;
  assign cur_dz = sel ? dz4 : dz1;
  assign cur_id = sel ? id4 : id1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    vid_t          id;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    vid_t          id;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dz;
    int            lat;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Results are compared when handed over; a flush or reset discards pending ones.
  always @(negedge clk) begin
    if (cur_ov && out_ready && !flush && !rst) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got q=%0d r=%0d with nothing pending", cur_q, cur_r);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_q", 32'(cur_q), 32'(e.q));
        check("res_r", 32'(cur_r), 32'(e.r));
        check("res_dz", 32'(cur_dz), 32'(e.dz));
        check("res_id", 32'(cur_id), 32'(e.id));
      end
    end
    if (flush || rst) sb.delete();
  end

  task automatic send(input logic [AW-1:0] ta, input logic [BW-1:0] tb_b, input vid_t tid,
                      input logic [AW-1:0] eq, input logic [BW-1:0] er, input logic edz);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    a = ta; b = tb_b; id = tid; in_valid = 1'b1;
    @(negedge clk);
    while (!cur_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ir) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles required 1", n);
    end else begin
      sb.push_back('{q: eq, r: er, dz: edz, id: tid});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the accept edge; returns the cycle out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    @(negedge clk);
    while (!cur_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic flush_seq(input logic s, input int exp_lat);
    int lat;
    logic seen;
    sel = s;
    out_ready = 1'b1;
    send(20'd1000, 16'd7, 4'd6, 20'd142, 16'd6, 1'b0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(cur_ir), 0);
    check("flush_busy_no_valid", 32'(cur_ov), 0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle_ready", 32'(cur_ir), 1);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (cur_ov) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 0);
    send(20'd100, 16'd6, 4'd7, 20'd16, 16'd4, 1'b0);
    wait_valid(lat);
    check("flush_next_lat", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    int lat;
    int n;
    logic seen;

    vecs[0]  = '{20'd524288,  16'd3,     4'd5,  20'd174762, 16'd2,     1'b0, 21};
    vecs[1]  = '{20'd524288,  16'd1024,  4'd1,  20'd512,    16'd0,     1'b0, 1};
    vecs[2]  = '{20'd12345,   16'd1,     4'd2,  20'd12345,  16'd0,     1'b0, 1};
    vecs[3]  = '{20'd77,      16'd0,     4'd3,  20'd0,      16'd77,    1'b1, 1};
    vecs[4]  = '{20'd1048575, 16'd65535, 4'd4,  20'd16,     16'd15,    1'b0, 21};
    vecs[5]  = '{20'd1048575, 16'd32768, 4'd8,  20'd31,     16'd32767, 1'b0, 1};
    vecs[6]  = '{20'd0,       16'd13,    4'd10, 20'd0,      16'd0,     1'b0, 21};
    vecs[7]  = '{20'd1048575, 16'd65534, 4'd11, 20'd16,     16'd31,    1'b0, 21};
    vecs[8]  = '{20'd70000,   16'd0,     4'd12, 20'd0,      16'd4464,  1'b1, 1};
    vecs[9]  = '{20'd100,     16'd6,     4'd13, 20'd16,     16'd4,     1'b0, 21};
    vecs[10] = '{20'd7,       16'd9,     4'd14, 20'd0,      16'd7,     1'b0, 21};
    vecs[11] = '{20'd999999,  16'd1000,  4'd15, 20'd999,    16'd999,   1'b0, 21};
    vecs[12] = '{20'd65536,   16'd65535, 4'd0,  20'd1,      16'd1,     1'b0, 21};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(cur_ir), 0);
    check("rst_out_valid", 32'(cur_ov), 0);
    check("rst_q", 32'(cur_q), 0);
    check("rst_r", 32'(cur_r), 0);
    check("rst_dz", 32'(cur_dz), 0);
    check("rst_id", 32'(cur_id), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].q, vecs[i].r, vecs[i].dz);
      wait_valid(lat);
      check($sformatf("lat[%0d]", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Result held while out_ready is low
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(20'd5, 16'd9, 4'd9, 20'd0, 16'd5, 1'b0);
    wait_valid(lat);
    check("hold_lat", 32'(lat), 21);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid", 32'(cur_ov), 1);
      check("hold_q", 32'(cur_q), 0);
      check("hold_r", 32'(cur_r), 5);
      check("hold_in_ready", 32'(cur_ir), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Back-to-back: second request taken on the DONE-exit edge
    send(20'd1000, 16'd7, 4'd3, 20'd142, 16'd6, 1'b0);
    a = 20'd1000; b = 16'd8; id = 4'd4; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cur_ir && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_accept_cycle", 32'(n + 1), 21);
    check("b2b_valid_at_accept", 32'(cur_ov), 1);
    if (cur_ir) sb.push_back('{q: 20'd125, r: 16'd0, dz: 1'b0, id: 4'd4});
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(lat);
    check("b2b_second_lat", 32'(lat), 1);

    // Flush mid-CALC, for both radices
    flush_seq(1'b0, 21);
    flush_seq(1'b1, 6);
    sel = 1'b0;

    // Flush together with out_ready in DONE: result not delivered
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(20'd77, 16'd0, 4'd2, 20'd0, 16'd77, 1'b1);
    wait_valid(lat);
    @(posedge clk);
    #1 begin flush = 1'b1; out_ready = 1'b1; end
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_done_valid", 32'(cur_ov), 0);

    // Reset mid-CALC: no result emitted
    send(20'd1000, 16'd7, 4'd5, 20'd142, 16'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(cur_ir), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (cur_ov) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 0);
    check("midrst_q", 32'(cur_q), 0);

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish within 500000 time units required finish");
    $fatal(1, "timeout");
  end

endmodule
